// File: rtl/rvfpm_issue_ctrl.sv
// Issue/retire controller for the rvfpm FPU: in-order instruction queue, a per-register
// busy scoreboard for RAW/WAW hazards, and a fixed-depth execution pipeline with writeback handshake.
module rvfpm_issue_ctrl #(
    parameter int X_ID_WIDTH      = 4,
    parameter int NUM_REGS        = 32,
    parameter int PIPELINE_STAGES = 4,
    parameter int QUEUE_DEPTH     = 4,
    localparam int RW             = $clog2(NUM_REGS),
    localparam int QCW            = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                                  ck,
    input  logic                                  rst,
    input  logic                                  enable,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [X_ID_WIDTH-1:0]                 in_id,
    input  logic [RW-1:0]                         in_rd,
    input  logic [RW-1:0]                         in_rs1,
    input  logic [RW-1:0]                         in_rs2,
    input  logic [RW-1:0]                         in_rs3,
    input  logic [2:0]                            in_rs_used,
    input  logic                                  in_we,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [X_ID_WIDTH-1:0]                 out_id,
    output logic [RW-1:0]                         out_rd,
    output logic                                  out_we,
    output logic [NUM_REGS-1:0]                   busy_regs,
    output logic [PIPELINE_STAGES*X_ID_WIDTH-1:0] pipe_ids,
    output logic [PIPELINE_STAGES-1:0]            pipe_valid,
    output logic [QCW-1:0]                        queue_count
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int S  = PIPELINE_STAGES;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic [RW-1:0]         rd;
        logic [RW-1:0]         rs1;
        logic [RW-1:0]         rs2;
        logic [RW-1:0]         rs3;
        logic [2:0]            rs_used;
        logic                  we;
    } instr_t;

    instr_t                q_mem [QUEUE_DEPTH];
    instr_t                head;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [QCW-1:0]        cnt_q, cnt_d;
    logic [S-1:0]          pv_q, pv_d;
    logic [X_ID_WIDTH-1:0] pid_q [S];
    logic [RW-1:0]         prd_q [S];
    logic                  pwe_q [S];
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic full, empty, hazard, stall, retire, accept, issue;

    // Wrap explicitly so non-power-of-2 depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head   = q_mem[head_q];
    assign full   = (cnt_q == QCW'(QUEUE_DEPTH));
    assign empty  = (cnt_q == '0);
    assign stall  = pv_q[S-1] && !out_ready;
    assign retire = pv_q[S-1] && out_ready;
    assign accept = in_valid && in_ready;
    assign issue  = !empty && enable && !stall && !hazard;

    always_comb begin
        hazard = 1'b0;
        if (head.rs_used[0] && busy_q[head.rs1]) hazard = 1'b1;
        if (head.rs_used[1] && busy_q[head.rs2]) hazard = 1'b1;
        if (head.rs_used[2] && busy_q[head.rs3]) hazard = 1'b1;
        if (head.we && busy_q[head.rd])          hazard = 1'b1;
    end

    always_comb begin
        head_d = issue  ? next_ptr(head_q) : head_q;
        tail_d = accept ? next_ptr(tail_q) : tail_q;
        cnt_d  = cnt_q;
        case ({accept, issue})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        pv_d = pv_q;
        if (!stall) begin
            for (int k = S - 1; k > 0; k--) pv_d[k] = pv_q[k-1];
            pv_d[0] = issue;
        end
        // Clear-on-retire and set-on-issue never hit the same register: issue waits on the busy bit.
        busy_d = busy_q;
        if (retire && pwe_q[S-1]) busy_d[prd_q[S-1]] = 1'b0;
        if (issue && head.we)     busy_d[head.rd]    = 1'b1;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            pv_q   <= '0;
            busy_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            pv_q   <= pv_d;
            busy_q <= busy_d;
        end
    end

    // Payload storage carries no reset; validity lives in the control state above.
    always_ff @(posedge ck) begin
        if (accept && !rst) begin
            q_mem[tail_q] <= '{id: in_id, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                               rs3: in_rs3, rs_used: in_rs_used, we: in_we};
        end
        if (!stall) begin
            pid_q[0] <= head.id;
            prd_q[0] <= head.rd;
            pwe_q[0] <= head.we;
            for (int k = 1; k < S; k++) begin
                pid_q[k] <= pid_q[k-1];
                prd_q[k] <= prd_q[k-1];
                pwe_q[k] <= pwe_q[k-1];
            end
        end
    end

    assign in_ready    = enable && !full;
    assign out_valid   = pv_q[S-1];
    assign out_id      = pv_q[S-1] ? pid_q[S-1] : '0;
    assign out_rd      = pv_q[S-1] ? prd_q[S-1] : '0;
    assign out_we      = pv_q[S-1] && pwe_q[S-1];
    assign busy_regs   = busy_q;
    assign pipe_valid  = pv_q;
    assign queue_count = cnt_q;

    for (genvar k = 0; k < S; k++) begin : g_pipe_ids
        assign pipe_ids[k*X_ID_WIDTH +: X_ID_WIDTH] = pv_q[k] ? pid_q[k] : '0;
    end

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Self-checking bench for rvfpm_issue_ctrl: cycle table for latency, scoreboard for retire order,
// hand sequences for hazards, backpressure, enable and mid-operation reset.
module tb_rvfpm_issue_ctrl;

    localparam int XW = 4;
    localparam int NR = 32;
    localparam int PS = 4;
    localparam int QD = 4;

    logic          ck = 1'b0;
    logic          rst, enable, in_valid, in_ready, in_we;
    logic [XW-1:0] in_id, out_id;
    logic [4:0]    in_rd, in_rs1, in_rs2, in_rs3, out_rd;
    logic [2:0]    in_rs_used;
    logic          out_valid, out_ready, out_we;
    logic [NR-1:0] busy_regs;
    logic [PS*XW-1:0] pipe_ids;
    logic [PS-1:0] pipe_valid;
    logic [2:0]    queue_count;

    rvfpm_issue_ctrl #(.X_ID_WIDTH(XW), .NUM_REGS(NR), .PIPELINE_STAGES(PS), .QUEUE_DEPTH(QD)) dut (
        .ck(ck), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_rs_used(in_rs_used), .in_we(in_we), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_rd(out_rd), .out_we(out_we), .busy_regs(busy_regs),
        .pipe_ids(pipe_ids), .pipe_valid(pipe_valid), .queue_count(queue_count)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [XW-1:0] id;
        logic [4:0]    rd;
        logic          we;
    } exp_t;

    exp_t sb[$];

    // Every accepted instruction must come back out exactly once, in order.
    always @(negedge ck) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin : retire_chk
                exp_t e;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got id %0h want none", out_id);
                end else begin
                    e = sb.pop_front();
                    chk("ret_id", 64'(out_id), 64'(e.id));
                    chk("ret_rd", 64'(out_rd), 64'(e.rd));
                    chk("ret_we", 64'(out_we), 64'(e.we));
                end
            end
            if (in_valid && in_ready) sb.push_back('{in_id, in_rd, in_we});
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic send(input logic [XW-1:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [2:0] used, input logic we);
        int n;
        in_valid = 1'b1; in_id = id; in_rd = rd; in_rs1 = rs1;
        in_rs2 = '0; in_rs3 = '0; in_rs_used = used; in_we = we;
        n = 0;
        @(negedge ck);
        while (!in_ready && n < 40) begin
            @(negedge ck);
            n++;
        end
        chk("send_ready", 64'(in_ready), 64'd1);
        @(posedge ck);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((pipe_valid != '0 || queue_count != '0) && n < 60) begin
            step();
            n++;
        end
        chk("idle", 64'(pipe_valid == '0 && queue_count == '0), 64'd1);
    endtask

    typedef struct {
        logic          vld;
        logic [XW-1:0] id;
        logic [4:0]    rd;
        logic          we;
        logic [2:0]    qc;
        logic [3:0]    pv;
        logic          ov;
        logic [XW-1:0] oid;
        logic [15:0]   pids;
        logic [31:0]   busy;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        tbl[0] = '{1'b1, 4'd3, 5'd5, 1'b1, 3'd1, 4'b0000, 1'b0, 4'd0, 16'h0000, 32'h0000_0000};
        tbl[1] = '{1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 4'b0001, 1'b0, 4'd0, 16'h0003, 32'h0000_0020};
        tbl[2] = '{1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 4'b0010, 1'b0, 4'd0, 16'h0030, 32'h0000_0020};
        tbl[3] = '{1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 4'b0100, 1'b0, 4'd0, 16'h0300, 32'h0000_0020};
        tbl[4] = '{1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 4'b1000, 1'b1, 4'd3, 16'h3000, 32'h0000_0020};
        tbl[5] = '{1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 4'b0000, 1'b0, 4'd0, 16'h0000, 32'h0000_0000};

        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_id = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_rs_used = '0; in_we = 1'b0;
        step();
        step();
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_id",    64'(out_id), 64'd0);
        chk("rst_busy",      64'(busy_regs), 64'd0);
        chk("rst_pipe_ids",  64'(pipe_ids), 64'd0);
        chk("rst_pipe_vld",  64'(pipe_valid), 64'd0);
        chk("rst_qcount",    64'(queue_count), 64'd0);
        rst = 1'b0;
        step();

        // Single instruction: accept, issue next edge, out_valid four edges later.
        for (int i = 0; i < 6; i++) begin
            in_valid = tbl[i].vld; in_id = tbl[i].id; in_rd = tbl[i].rd; in_we = tbl[i].we;
            in_rs_used = '0;
            step();
            chk($sformatf("lat_qc[%0d]", i),   64'(queue_count), 64'(tbl[i].qc));
            chk($sformatf("lat_pv[%0d]", i),   64'(pipe_valid),  64'(tbl[i].pv));
            chk($sformatf("lat_ov[%0d]", i),   64'(out_valid),   64'(tbl[i].ov));
            chk($sformatf("lat_oid[%0d]", i),  64'(out_id),      64'(tbl[i].oid));
            chk($sformatf("lat_pids[%0d]", i), 64'(pipe_ids),    64'(tbl[i].pids));
            chk($sformatf("lat_busy[%0d]", i), 64'(busy_regs),   64'(tbl[i].busy));
        end
        in_valid = 1'b0;
        wait_idle();

        // RAW: id2 reads f2 written by id1 and may issue only the edge after id1 retires.
        send(4'd1, 5'd2, 5'd0, 3'b000, 1'b1);
        send(4'd2, 5'd7, 5'd2, 3'b001, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) step();
        chk("raw_first_id", 64'(out_id), 64'd1);
        chk("raw_pv_first", 64'(pipe_valid), 64'b1000);
        chk("raw_held_q",   64'(queue_count), 64'd1);
        step();
        chk("raw_no_fwd_q", 64'(queue_count), 64'd1);
        chk("raw_busy2_clr", 64'(busy_regs[2]), 64'd0);
        chk("raw_pv_gap",   64'(pipe_valid), 64'd0);
        step();
        chk("raw_issue_pv", 64'(pipe_valid), 64'b0001);
        chk("raw_issue_id", 64'(pipe_ids[3:0]), 64'd2);
        chk("raw_busy7",    64'(busy_regs[7]), 64'd1);
        wait_idle();

        // Fill pipeline and queue under backpressure, then release.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(XW'(i), 5'(i), 5'd0, 3'b000, 1'b1);
        chk("full_qc",    64'(queue_count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_pv",    64'(pipe_valid), 64'hF);
        chk("full_pids",  64'(pipe_ids), 64'h1234);
        in_valid = 1'b1; in_id = 4'd9; in_rd = 5'd9; in_rs_used = '0; in_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_pids[%0d]", i), 64'(pipe_ids), 64'h1234);
            chk($sformatf("bp_qc[%0d]", i),   64'(queue_count), 64'd4);
        end
        out_ready = 1'b1;
        @(negedge ck);
        chk("full_pop_ready", 64'(in_ready), 64'd0);
        @(posedge ck);
        #1;
        chk("rel_qc0", 64'(queue_count), 64'd3);
        chk("rel_ov0", 64'(out_valid), 64'd1);
        step();
        in_valid = 1'b0;
        chk("rel_qc1", 64'(queue_count), 64'd3);
        chk("rel_ov1", 64'(out_valid), 64'd1);
        step();
        chk("rel_ov2", 64'(out_valid), 64'd1);
        step();
        chk("rel_ov3", 64'(out_valid), 64'd1);
        wait_idle();

        // enable=0 with two queued, two in flight: flight drains, queue holds.
        send(4'd10, 5'd10, 5'd0,  3'b000, 1'b1);
        send(4'd11, 5'd11, 5'd0,  3'b000, 1'b1);
        send(4'd12, 5'd13, 5'd11, 3'b001, 1'b1);
        send(4'd13, 5'd12, 5'd0,  3'b000, 1'b1);
        chk("en_qc_pre",   64'(queue_count), 64'd2);
        chk("en_pv_pre",   64'(pipe_valid), 64'b0110);
        chk("en_busy_pre", 64'(busy_regs), 64'h0C00);
        enable = 1'b0;
        #1;
        chk("en_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) step();
        chk("en_qc_hold", 64'(queue_count), 64'd2);
        chk("en_pv_drain", 64'(pipe_valid), 64'd0);
        chk("en_busy_clr", 64'(busy_regs), 64'd0);
        enable = 1'b1;
        step();
        chk("en_resume_pv", 64'(pipe_valid), 64'b0001);
        chk("en_resume_id", 64'(pipe_ids[3:0]), 64'd12);
        chk("en_resume_qc", 64'(queue_count), 64'd1);
        wait_idle();

        // Reset with work queued and in flight: everything is discarded.
        send(4'd1, 5'd4, 5'd0, 3'b000, 1'b1);
        send(4'd2, 5'd5, 5'd0, 3'b000, 1'b1);
        send(4'd3, 5'd8, 5'd5, 3'b001, 1'b1);
        send(4'd4, 5'd6, 5'd0, 3'b000, 1'b1);
        send(4'd5, 5'd7, 5'd0, 3'b000, 1'b1);
        chk("mr_qc_pre",   64'(queue_count), 64'd3);
        chk("mr_busy_pre", 64'(busy_regs), 64'h30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_ready",    64'(in_ready), 64'd1);
        chk("mr_ov",       64'(out_valid), 64'd0);
        chk("mr_oid",      64'(out_id), 64'd0);
        chk("mr_ord",      64'(out_rd), 64'd0);
        chk("mr_owe",      64'(out_we), 64'd0);
        chk("mr_busy",     64'(busy_regs), 64'd0);
        chk("mr_pids",     64'(pipe_ids), 64'd0);
        chk("mr_pv",       64'(pipe_valid), 64'd0);
        chk("mr_qc",       64'(queue_count), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            seen = seen | out_valid;
        end
        chk("mr_no_ghost", 64'(seen), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
